// File: rtl/bht_update_ctrl_if.sv
// BHT controller bundle: fetch lookup, execute resolution, table port, status.
// Latency: none (plain signal container).
// Backpressure: res_valid/res_ready on resolutions; lu_stall tells fetch to retry.
interface bht_update_ctrl_if #(
  parameter int PC_W  = 32,
  parameter int IDX_W = 10,
  parameter int CNT_W = 3
);
  logic             lu_valid;
  logic [PC_W-1:0]  lu_pc;
  logic             lu_pred;
  logic [1:0]       lu_ctr;
  logic             lu_stall;

  logic             res_valid;
  logic             res_ready;
  logic [PC_W-1:0]  res_pc;
  logic             res_taken;

  logic [IDX_W-1:0] tbl_addr;
  logic [1:0]       tbl_rdata;
  logic [1:0]       tbl_wdata;
  logic             tbl_we;

  logic             busy;
  logic [CNT_W-1:0] fifo_count;

  // Environment side: fetch, execute and the table array.
  modport master (
    output lu_valid, lu_pc, res_valid, res_pc, res_taken, tbl_rdata,
    input  lu_pred, lu_ctr, lu_stall, res_ready, tbl_addr, tbl_wdata, tbl_we,
    input  busy, fifo_count
  );

  // Controller side.
  modport slave (
    input  lu_valid, lu_pc, res_valid, res_pc, res_taken, tbl_rdata,
    output lu_pred, lu_ctr, lu_stall, res_ready, tbl_addr, tbl_wdata, tbl_we,
    output busy, fifo_count
  );
endinterface

// File: rtl/bht_update_ctrl.sv
// Owns the single BHT port: zero-latency lookups plus queued 2-bit counter RMW updates.
// Latency: lookup same cycle; an update needs >=1 RD cycle and 1 WR cycle after it reaches the head.
// Backpressure: res_ready low when the FIFO is full; lu_stall only while a starved update forces the port.
module bht_update_ctrl #(
  parameter int PC_W       = 32,
  parameter int IDX_W      = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic clk,
  input  logic reset,
  bht_update_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int SW    = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t           state;
  logic [IDX_W:0]   mem [FIFO_DEPTH];   // {index, taken}
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count, count_nxt;
  logic [1:0]       ctr_q;
  logic [SW-1:0]    starve_cnt;

  logic [IDX_W-1:0] lu_idx, res_idx, head_idx;
  logic             head_taken;
  logic             forcing, lu_served, rd_fire, wr_fire, push, pop;
  logic             unused_pc;

  // Saturating 2-bit counter step.
  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'b01;
    else       return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  assign lu_idx     = bus.lu_pc[IDX_W+1:2];
  assign res_idx    = bus.res_pc[IDX_W+1:2];
  assign head_idx   = mem[rd_ptr][IDX_W:1];
  assign head_taken = mem[rd_ptr][0];
  // PC bits outside the index field carry no table information.
  assign unused_pc  = ^{bus.lu_pc[PC_W-1:IDX_W+2], bus.lu_pc[1:0],
                        bus.res_pc[PC_W-1:IDX_W+2], bus.res_pc[1:0]};

  // Port arbitration: lookups win unless a starved WR is forcing its write.
  always_comb begin
    forcing   = (state == WR) && (starve_cnt == SW'(STARVE_MAX));
    lu_served = bus.lu_valid && !forcing;
    rd_fire   = (state == RD) && !bus.lu_valid;
    // A write in the reset cycle is suppressed so an interrupted RMW leaves the table untouched.
    wr_fire   = (state == WR) && (!bus.lu_valid || forcing) && !reset;
    push      = bus.res_valid && bus.res_ready;
    pop       = wr_fire;

    bus.res_ready  = (count != CNT_W'(FIFO_DEPTH));
    bus.tbl_addr   = lu_served ? lu_idx : head_idx;
    bus.tbl_we     = wr_fire;
    bus.tbl_wdata  = ctr_next(ctr_q, head_taken);
    bus.lu_stall   = bus.lu_valid && forcing;
    bus.lu_ctr     = lu_served ? bus.tbl_rdata : 2'b00;
    bus.lu_pred    = lu_served ? bus.tbl_rdata[1] : 1'b0;
    bus.busy       = (count != '0) || (state != IDLE);
    bus.fifo_count = count;

    count_nxt = count;
    if (push && !pop)      count_nxt = count + CNT_W'(1);
    else if (!push && pop) count_nxt = count - CNT_W'(1);
  end

  // FIFO payload storage; validity is tracked by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {res_idx, bus.res_taken};
  end

  // FIFO pointers and the IDLE/RD/WR update sequencer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      ctr_q      <= 2'b00;
      starve_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      case (state)
        IDLE: if (count != '0) state <= RD;
        RD: begin
          if (rd_fire) begin
            ctr_q <= bus.tbl_rdata;
            state <= WR;
          end
        end
        WR: begin
          if (wr_fire) begin
            starve_cnt <= '0;
            state      <= (count_nxt != '0) ? RD : IDLE;
          end else if (starve_cnt != SW'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + SW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
